// File: rtl/dot_accum.sv
// Dot-product accumulator: sums LEN unsigned products and offers the sum on a valid/ready port.
// Latency: out_vld registers one cycle after the LEN-th accepted beat; in_rdy is low while a result is held.
// Backpressure: out_rdy low holds the result stable. DOT_ACCUM_SAT_EN selects saturating accumulation.
module dot_accum #(
   parameter int BIT_SZ = 16,
   parameter int ACC_SZ = 24,
   parameter int LEN    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              in_vld,
   output logic              in_rdy,
   input  logic [BIT_SZ-1:0] in_data,
   output logic              out_vld,
   input  logic              out_rdy,
   output logic [ACC_SZ-1:0] out_sum,
   output logic              out_ovf
);

   localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

   typedef enum logic {ACCUM, HOLD} state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [ACC_SZ-1:0] acc;
   logic [ACC_SZ-1:0] acc_nxt;
   logic [ACC_SZ:0]   sum_raw;
   logic              ovf;
   logic              carry;
   logic              accept;

   assign in_rdy  = (state == ACCUM) && !clr;
   assign accept  = in_vld && in_rdy;
   assign sum_raw = {1'b0, acc} + (ACC_SZ+1)'(in_data);
   assign carry   = sum_raw[ACC_SZ];

`ifdef DOT_ACCUM_SAT_EN
   // once saturated, the accumulator pins at all ones for the rest of the vector
   assign acc_nxt = (carry || ovf) ? '1 : sum_raw[ACC_SZ-1:0];
`else
   assign acc_nxt = sum_raw[ACC_SZ-1:0];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ACCUM;
         cnt     <= '0;
         acc     <= '0;
         ovf     <= 1'b0;
         out_sum <= '0;
         out_vld <= 1'b0;
         out_ovf <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               if (clr) begin
                  acc <= '0;
                  cnt <= '0;
                  ovf <= 1'b0;
               end else if (accept) begin
                  if (cnt == LAST) begin
                     out_sum <= acc_nxt;
                     out_ovf <= ovf | carry;
                     out_vld <= 1'b1;
                     acc     <= '0;
                     cnt     <= '0;
                     ovf     <= 1'b0;
                     state   <= HOLD;
                  end else begin
                     acc <= acc_nxt;
                     cnt <= cnt + CNT_W'(1);
                     ovf <= ovf | carry;
                  end
               end
            end
            HOLD: begin
               if (out_rdy) begin
                  out_vld <= 1'b0;
                  state   <= ACCUM;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

endmodule

// File: tb/tb_dot_accum.sv
// Bench for dot_accum (ACC_SZ=17, LEN=4): directed steps then random traffic against a vector-level model.
module tb_dot_accum;

   localparam int BIT_SZ = 16;
   localparam int ACC_SZ = 17;
   localparam int LEN    = 4;
   localparam longint MOD  = longint'(1) << ACC_SZ;

   logic              clk = 1'b0;
   logic              rst;
   logic              clr;
   logic              in_vld;
   logic              in_rdy;
   logic [BIT_SZ-1:0] in_data;
   logic              out_vld;
   logic              out_rdy;
   logic [ACC_SZ-1:0] out_sum;
   logic              out_ovf;

   int total = 0;
   int bad   = 0;

   // reference model state: beats of the vector in progress and the last result
   longint beats[$];
   bit     holding;
   bit     exp_vld;
   bit     exp_ovf;
   longint exp_sum;

   dot_accum #(.BIT_SZ(BIT_SZ), .ACC_SZ(ACC_SZ), .LEN(LEN)) dut (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .in_vld  (in_vld),
      .in_rdy  (in_rdy),
      .in_data (in_data),
      .out_vld (out_vld),
      .out_rdy (out_rdy),
      .out_sum (out_sum),
      .out_ovf (out_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint obs, input longint exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      beats.delete();
      holding = 1'b0;
      exp_vld = 1'b0;
      exp_ovf = 1'b0;
      exp_sum = 0;
   endtask

   task automatic finish_vector();
      longint tot;
      tot = 0;
      foreach (beats[i]) tot += beats[i];
`ifdef DOT_ACCUM_SAT_EN
      exp_sum = (tot >= MOD) ? MOD - 1 : tot;
`else
      exp_sum = tot % MOD;
`endif
      exp_ovf = (tot >= MOD);
      exp_vld = 1'b1;
      holding = 1'b1;
      beats.delete();
   endtask

   // one clock: drive inputs, check in_rdy, clock, update model, check outputs
   task automatic step(input bit v, input int d, input bit c, input bit r);
      bit take;
      in_vld  = v;
      in_data = BIT_SZ'(d);
      clr     = c;
      out_rdy = r;
      #1;
      take = !holding && !c;
      chk("in_rdy", longint'(in_rdy), longint'(take));
      @(posedge clk);
      if (holding) begin
         if (r) begin
            holding = 1'b0;
            exp_vld = 1'b0;
         end
      end else if (c) begin
         beats.delete();
      end else if (v) begin
         beats.push_back(longint'(d));
         if (beats.size() == LEN) finish_vector();
      end
      #1;
      chk("out_vld", longint'(out_vld), longint'(exp_vld));
      chk("out_sum", longint'(out_sum), exp_sum);
      chk("out_ovf", longint'(out_ovf), longint'(exp_ovf));
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_vld"}, longint'(out_vld), 0);
      chk({tag, "_sum"}, longint'(out_sum), 0);
      chk({tag, "_ovf"}, longint'(out_ovf), 0);
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; in_vld = 1'b0; in_data = '0; out_rdy = 1'b0;
      model_reset();
      #1;
      check_zero("reset");
      chk("reset_in_rdy", longint'(in_rdy), 1);
      #12 rst = 1'b0;

      // basic sum
      for (int i = 1; i <= 4; i++) step(1, i, 0, 1);
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);

      // backpressure, with a beat offered during HOLD
      for (int i = 0; i < 4; i++) step(1, 5, 0, 0);
      for (int i = 0; i < 5; i++) step(1, 7, 0, 0);
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);

      // overflow, then a clean vector
      for (int i = 0; i < 4; i++) step(1, 'hFFFF, 0, 1);
      step(0, 0, 0, 1);
      for (int i = 0; i < 4; i++) step(1, 1, 0, 1);
      step(0, 0, 0, 1);

      // clear mid-vector, then clear while holding
      step(1, 9, 0, 1);
      step(1, 9, 0, 1);
      step(1, 9, 1, 1);
      for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
      step(0, 0, 1, 0);
      step(1, 3, 1, 0);
      step(0, 0, 0, 1);

      // reset mid-vector
      step(1, 3, 0, 1);
      step(1, 3, 0, 1);
      rst = 1'b1;
      #1;
      check_zero("rst_mid");
      #1 rst = 1'b0;
      model_reset();
      for (int i = 0; i < 4; i++) step(1, 2, 0, 1);
      step(0, 0, 0, 1);

      // gapped input
      for (int i = 1; i <= 4; i++) begin
         step(1, i, 0, 1);
         if (i < 4) begin
            step(0, 'hABCD, 0, 1);
            step(0, 'h1234, 0, 1);
         end
      end
      step(0, 0, 0, 1);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom % 4) != 0,
              int'($urandom_range(0, 65535)),
              ($urandom % 16) == 0,
              ($urandom % 3) != 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
